ctrl_decode_pipe: RTL and testbench
===================================

// Module: ctrl_decode_pipe
// PURPOSE
//   Next-generation instruction control unit for the ARM core ID stage. Decodes mode/opcode/S/I
//   into the execute/memory/writeback control bundle and carries it through a parametrised run of
//   ID/EX control registers with stall, flush, illegal-instruction flagging and automatic branch-shadow squash.
//   Sits between the instruction decoder and the EXE stage; hazard unit drives stall, branch resolution drives flush.
// PARAMETERS
//   CMD_W          4  execute_command width (>=4); codes zero-extended to CMD_W
//   PIPE_DEPTH     1  number of control register stages, 1..4 (latency = PIPE_DEPTH cycles)
//   BRANCH_SHADOW  1  accepted instructions squashed after an accepted branch, 0..3
// PORTS
//   clk                  in   1      clock, rising edge
//   rst                  in   1      asynchronous, active-low reset
//   in_valid             in   1      decode inputs carry a real instruction
//   mode                 in   2      00 data-proc, 01 memory, 10 branch, 11 illegal
//   opcode               in   4      data-proc opcode
//   s                    in   1      S bit (data-proc: set flags; memory: 1=LDR, 0=STR)
//   imm_in               in   1      I bit
//   stall                in   1      hold all stages; input not consumed
//   flush                in   1      kill all in-flight entries and branch shadow
//   out_valid            out  1      last stage holds a live instruction
//   execute_command      out  CMD_W  ALU command
//   mem_read, mem_write  out  1      memory controls
//   wb_enable            out  1      register writeback
//   immediate            out  1      use immediate operand
//   branch_taken         out  1      branch instruction
//   status_write_enable  out  1      update NZCV
//   ignore_hazard        out  1      instruction reads no Rn
//   illegal              out  1      undefined mode/opcode (valid entry, all enables 0)
// BEHAVIOUR
//   Decode (mode 00): MOV 1101->0001 wb,ign; MVN 1111->1001 wb,ign; ADD 0100->0010; ADC 0101->0011;
//     SUB 0010->0100; SBC 0110->0101; AND 0000->0110; ORR 1100->0111; EOR 0001->1000 (all wb);
//     CMP 1010->1100, TST 1000->1110: no wb, status_write_enable forced 1; others: sws=s. Other opcodes: illegal.
//   mode 01: cmd 0010 (ADD); s=1 mem_read+wb_enable; s=0 mem_write; sws=0. mode 10: branch_taken+ignore_hazard,
//     cmd 0, immediate 0, sws 0. mode 11: illegal. immediate=imm_in for modes 00/01.
//   Stage 0 captures decode when !stall; stage k captures stage k-1 when !stall. Outputs come from last stage.
//   Any entry with valid=0 drives every control output, execute_command and illegal to 0.
//   Illegal entries: out_valid=1, illegal=1, all enables 0, execute_command 0.
//   stall: every stage and shadow counter hold; in_valid ignored that cycle.
//   flush: next edge clears all stage valids and shadow counter to 0; flush has priority over stall.
//   Shadow counter (2 bit): accepted valid branch (not itself squashed) loads BRANCH_SHADOW;
//     while counter>0 each accepted valid input enters as bubble (valid=0) and counter decrements;
//     a branch arriving in the shadow is squashed and does not reload. Invalid inputs do not decrement.
//   flush and accepted branch same edge: flush wins, branch dropped, counter 0.
//   Reset (rst=0, async): all stage valids 0, counter 0; so all outputs 0 immediately, incl. mid-flight.
// TESTING
//   PIPE_DEPTH=1: ADD (00,0100,s=1,i=0) -> next cycle out_valid=1, cmd=0010, wb=1, sws=1, others 0.
//   PIPE_DEPTH=3: MOV,CMP,LDR back-to-back -> outputs appear cycles 3,4,5; CMP wb=0 sws=1 cmd=1100; LDR cmd=0010 rd=1 wb=1.
//   Stall 2 cycles with SUB in last stage -> cmd=0100 held 2 extra cycles; input during stall not captured.
//   BRANCH_SHADOW=2: B,ADD,ORR,EOR -> B emerges, then two bubbles (out_valid=0), then EOR cmd=1000.
//   mode=11 and mode 00 opcode 0011 -> out_valid=1, illegal=1, all enables 0, cmd=0.
//   Flush with stall=1 and 3 live entries, then rst low mid-stream -> all outputs 0, counter 0, no squash of next instr.

Source files
------------

// File: rtl/ctrl_decode_pipe_if.sv
// Decode-side request and control-bundle response between the ID decoder, the hazard/branch units and EXE.
// Keeps the original signal names so the bundle reads the same at every boundary.
interface ctrl_decode_pipe_if #(
    parameter int unsigned CMD_W = 4
);
    logic             in_valid;
    logic [1:0]       mode;
    logic [3:0]       opcode;
    logic             s;
    logic             imm_in;
    logic             stall;
    logic             flush;

    logic             out_valid;
    logic [CMD_W-1:0] execute_command;
    logic             mem_read;
    logic             mem_write;
    logic             wb_enable;
    logic             immediate;
    logic             branch_taken;
    logic             status_write_enable;
    logic             ignore_hazard;
    logic             illegal;

    modport master (
        output in_valid, mode, opcode, s, imm_in, stall, flush,
        input  out_valid, execute_command, mem_read, mem_write, wb_enable,
               immediate, branch_taken, status_write_enable, ignore_hazard, illegal
    );

    modport slave (
        input  in_valid, mode, opcode, s, imm_in, stall, flush,
        output out_valid, execute_command, mem_read, mem_write, wb_enable,
               immediate, branch_taken, status_write_enable, ignore_hazard, illegal
    );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// ID-stage control decode feeding a PIPE_DEPTH-deep run of ID/EX control registers,
// with stall/flush, illegal flagging and squash of the instructions shadowing a taken branch.
module ctrl_decode_pipe #(
    parameter int unsigned CMD_W         = 4,
    parameter int unsigned PIPE_DEPTH    = 1,
    parameter int unsigned BRANCH_SHADOW = 1
) (
    input logic               clk,
    input logic               rst,
    ctrl_decode_pipe_if.slave bus
);

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    typedef struct packed {
        logic             valid;
        logic             illegal;
        logic [CMD_W-1:0] cmd;
        logic             mem_read;
        logic             mem_write;
        logic             wb_enable;
        logic             immediate;
        logic             branch_taken;
        logic             sws;
        logic             ign;
    } ctrl_t;

    ctrl_t      dec_c;
    ctrl_t      entry_c;
    ctrl_t      stage_q [PIPE_DEPTH];
    ctrl_t      stage_d [PIPE_DEPTH];
    logic [1:0] shadow_q;
    logic [1:0] shadow_d;
    ctrl_t      last_c;

    // Pure decode of the current instruction fields; valid is attached by the accept logic.
    always_comb begin
        dec_c = '0;
        case (bus.mode)
            MODE_DP: begin
                dec_c.immediate = bus.imm_in;
                dec_c.sws       = bus.s;
                dec_c.wb_enable = 1'b1;
                case (bus.opcode)
                    4'b1101: begin dec_c.cmd = CMD_W'(4'b0001); dec_c.ign = 1'b1; end
                    4'b1111: begin dec_c.cmd = CMD_W'(4'b1001); dec_c.ign = 1'b1; end
                    4'b0100: dec_c.cmd = CMD_W'(4'b0010);
                    4'b0101: dec_c.cmd = CMD_W'(4'b0011);
                    4'b0010: dec_c.cmd = CMD_W'(4'b0100);
                    4'b0110: dec_c.cmd = CMD_W'(4'b0101);
                    4'b0000: dec_c.cmd = CMD_W'(4'b0110);
                    4'b1100: dec_c.cmd = CMD_W'(4'b0111);
                    4'b0001: dec_c.cmd = CMD_W'(4'b1000);
                    4'b1010: begin
                        dec_c.cmd       = CMD_W'(4'b1100);
                        dec_c.wb_enable = 1'b0;
                        dec_c.sws       = 1'b1;
                    end
                    4'b1000: begin
                        dec_c.cmd       = CMD_W'(4'b1110);
                        dec_c.wb_enable = 1'b0;
                        dec_c.sws       = 1'b1;
                    end
                    default: begin
                        dec_c         = '0;
                        dec_c.illegal = 1'b1;
                    end
                endcase
            end
            MODE_MEM: begin
                dec_c.cmd       = CMD_W'(4'b0010);
                dec_c.immediate = bus.imm_in;
                dec_c.mem_read  = bus.s;
                dec_c.wb_enable = bus.s;
                dec_c.mem_write = ~bus.s;
            end
            MODE_BR: begin
                dec_c.branch_taken = 1'b1;
                dec_c.ign          = 1'b1;
            end
            default: dec_c.illegal = 1'b1;
        endcase
    end

    // Accept logic: inputs inside the branch shadow become bubbles; only a surviving branch reloads.
    always_comb begin
        entry_c  = '0;
        shadow_d = shadow_q;
        if (bus.flush) begin
            shadow_d = 2'd0;
        end else if (!bus.stall && bus.in_valid) begin
            if (shadow_q != 2'd0) begin
                shadow_d = shadow_q - 2'd1;
            end else begin
                entry_c       = dec_c;
                entry_c.valid = 1'b1;
                if (dec_c.branch_taken) begin
                    shadow_d = 2'(BRANCH_SHADOW);
                end
            end
        end
    end

    // Stage advance; flush outranks stall.
    always_comb begin
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (bus.flush) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                stage_d[k] = '0;
            end
        end else if (!bus.stall) begin
            stage_d[0] = entry_c;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            shadow_q <= 2'd0;
        end else begin
            stage_q  <= stage_d;
            shadow_q <= shadow_d;
        end
    end

    // Bubbles are stored as all-zero entries, so the last stage drives the outputs directly.
    assign last_c                  = stage_q[PIPE_DEPTH-1];
    assign bus.out_valid           = last_c.valid;
    assign bus.illegal             = last_c.illegal;
    assign bus.execute_command     = last_c.cmd;
    assign bus.mem_read            = last_c.mem_read;
    assign bus.mem_write           = last_c.mem_write;
    assign bus.wb_enable           = last_c.wb_enable;
    assign bus.immediate           = last_c.immediate;
    assign bus.branch_taken        = last_c.branch_taken;
    assign bus.status_write_enable = last_c.sws;
    assign bus.ignore_hazard       = last_c.ign;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: two instances (depth 1/shadow 1 and depth 3/shadow 2) driven in lockstep,
// checked against decode tables, hand-written corner sequences and a history-queue reference model.
module tb_ctrl_decode_pipe;

    localparam int unsigned DA = 1;
    localparam int unsigned SA = 1;
    localparam int unsigned DB = 3;
    localparam int unsigned SB = 2;

    typedef struct packed {
        logic       valid;
        logic       ill;
        logic [3:0] cmd;
        logic       rd;
        logic       wr;
        logic       wb;
        logic       imm;
        logic       br;
        logic       sws;
        logic       ign;
    } exp_t;

    typedef struct packed {
        logic       iv;
        logic [1:0] mode;
        logic [3:0] op;
        logic       s;
        logic       i;
        exp_t       e;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [1:0] mode;
    logic [3:0] opcode;
    logic       s;
    logic       imm_in;
    logic       stall;
    logic       flush;

    int n_checks = 0;
    int n_fail   = 0;

    ctrl_decode_pipe_if #(.CMD_W(4)) ifa ();
    ctrl_decode_pipe_if #(.CMD_W(4)) ifb ();

    assign ifa.in_valid = in_valid;
    assign ifa.mode     = mode;
    assign ifa.opcode   = opcode;
    assign ifa.s        = s;
    assign ifa.imm_in   = imm_in;
    assign ifa.stall    = stall;
    assign ifa.flush    = flush;
    assign ifb.in_valid = in_valid;
    assign ifb.mode     = mode;
    assign ifb.opcode   = opcode;
    assign ifb.s        = s;
    assign ifb.imm_in   = imm_in;
    assign ifb.stall    = stall;
    assign ifb.flush    = flush;

    ctrl_decode_pipe #(.CMD_W(4), .PIPE_DEPTH(DA), .BRANCH_SHADOW(SA)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    ctrl_decode_pipe #(.CMD_W(4), .PIPE_DEPTH(DB), .BRANCH_SHADOW(SB)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: every accepted edge appends one entry; the output is the entry pushed depth edges ago.
    exp_t hist_a[$];
    exp_t hist_b[$];
    int   shadow[2];

    function automatic exp_t mk_e(logic v, logic ill, logic [3:0] cmd, logic rd, logic wr,
                                  logic wb, logic imm, logic br, logic sws, logic ign);
        exp_t e;
        e = '{valid:v, ill:ill, cmd:cmd, rd:rd, wr:wr, wb:wb, imm:imm, br:br, sws:sws, ign:ign};
        return e;
    endfunction

    function automatic exp_t ref_decode(logic [1:0] m, logic [3:0] op, logic sb, logic ib);
        exp_t e = '0;
        e.valid = 1'b1;
        if (m == 2'b00) begin
            e.wb = 1'b1; e.imm = ib; e.sws = sb;
            case (op)
                4'b1101: begin e.cmd = 4'b0001; e.ign = 1'b1; end
                4'b1111: begin e.cmd = 4'b1001; e.ign = 1'b1; end
                4'b0100: e.cmd = 4'b0010;
                4'b0101: e.cmd = 4'b0011;
                4'b0010: e.cmd = 4'b0100;
                4'b0110: e.cmd = 4'b0101;
                4'b0000: e.cmd = 4'b0110;
                4'b1100: e.cmd = 4'b0111;
                4'b0001: e.cmd = 4'b1000;
                4'b1010: begin e.cmd = 4'b1100; e.wb = 1'b0; e.sws = 1'b1; end
                4'b1000: begin e.cmd = 4'b1110; e.wb = 1'b0; e.sws = 1'b1; end
                default: e = mk_e(1, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
            endcase
        end else if (m == 2'b01) begin
            e.cmd = 4'b0010; e.imm = ib; e.rd = sb; e.wb = sb; e.wr = ~sb;
        end else if (m == 2'b10) begin
            e.br = 1'b1; e.ign = 1'b1;
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic push(input int id, input exp_t e);
        if (id == 0) begin
            hist_a.push_back(e);
            if (hist_a.size() > 8) void'(hist_a.pop_front());
        end else begin
            hist_b.push_back(e);
            if (hist_b.size() > 8) void'(hist_b.pop_front());
        end
    endtask

    function automatic exp_t model_out(int id);
        if (id == 0) return hist_a[hist_a.size() - DA];
        return hist_b[hist_b.size() - DB];
    endfunction

    task automatic model_reset();
        hist_a.delete();
        hist_b.delete();
        for (int k = 0; k < DA; k++) hist_a.push_back('0);
        for (int k = 0; k < DB; k++) hist_b.push_back('0);
        shadow[0] = 0;
        shadow[1] = 0;
    endtask

    task automatic model_edge(input int id);
        int   d  = (id == 0) ? DA : DB;
        int   bs = (id == 0) ? SA : SB;
        exp_t e;
        if (flush) begin
            for (int k = 0; k < d; k++) push(id, '0);
            shadow[id] = 0;
        end else if (!stall) begin
            if (!in_valid) begin
                push(id, '0);
            end else if (shadow[id] > 0) begin
                push(id, '0);
                shadow[id] = shadow[id] - 1;
            end else begin
                e = ref_decode(mode, opcode, s, imm_in);
                push(id, e);
                if (e.br) shadow[id] = bs;
            end
        end
    endtask

    function automatic exp_t act(int id);
        if (id == 0)
            return {ifa.out_valid, ifa.illegal, ifa.execute_command, ifa.mem_read, ifa.mem_write,
                    ifa.wb_enable, ifa.immediate, ifa.branch_taken, ifa.status_write_enable,
                    ifa.ignore_hazard};
        return {ifb.out_valid, ifb.illegal, ifb.execute_command, ifb.mem_read, ifb.mem_write,
                ifb.wb_enable, ifb.immediate, ifb.branch_taken, ifb.status_write_enable,
                ifb.ignore_hazard};
    endfunction

    task automatic cmp(input string name, input exp_t got, input exp_t want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b required %b (v,ill,cmd,rd,wr,wb,imm,br,sws,ign)",
                     name, $time, got, want);
        end
    endtask

    task automatic drive(input logic iv, input logic [1:0] m, input logic [3:0] op,
                         input logic sb, input logic ib);
        in_valid = iv; mode = m; opcode = op; s = sb; imm_in = ib;
    endtask

    task automatic idle();
        drive(0, 2'b00, 4'b0000, 0, 0);
        stall = 1'b0;
        flush = 1'b0;
    endtask

    // One clock: model advances on the same edge as the DUTs, outputs compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        cmp("model_a", act(0), model_out(0));
        cmp("model_b", act(1), model_out(1));
    endtask

    vec_t vec[19];

    function automatic vec_t mkv(logic iv, logic [1:0] m, logic [3:0] op, logic sb, logic ib,
                                 exp_t e);
        vec_t v;
        v = '{iv:iv, mode:m, op:op, s:sb, i:ib, e:e};
        return v;
    endfunction

    exp_t e_add, e_sub, e_and, e_orr, e_eor, e_mov, e_cmp, e_ldr, e_b, e_ill;

    initial begin
        e_mov = mk_e(1, 0, 4'b0001, 0, 0, 1, 1, 0, 0, 1);
        e_cmp = mk_e(1, 0, 4'b1100, 0, 0, 0, 0, 0, 1, 0);
        e_ldr = mk_e(1, 0, 4'b0010, 1, 0, 1, 0, 0, 0, 0);
        e_sub = mk_e(1, 0, 4'b0100, 0, 0, 1, 0, 0, 0, 0);
        e_add = mk_e(1, 0, 4'b0010, 0, 0, 1, 0, 0, 0, 0);
        e_orr = mk_e(1, 0, 4'b0111, 0, 0, 1, 0, 0, 0, 0);
        e_eor = mk_e(1, 0, 4'b1000, 0, 0, 1, 0, 0, 0, 0);
        e_b   = mk_e(1, 0, 4'b0000, 0, 0, 0, 0, 1, 0, 1);
        e_ill = mk_e(1, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);

        vec[0]  = mkv(1, 2'b00, 4'b0100, 1, 0, mk_e(1, 0, 4'b0010, 0, 0, 1, 0, 0, 1, 0));
        vec[1]  = mkv(1, 2'b00, 4'b1101, 0, 1, e_mov);
        vec[2]  = mkv(1, 2'b00, 4'b1111, 1, 0, mk_e(1, 0, 4'b1001, 0, 0, 1, 0, 0, 1, 1));
        vec[3]  = mkv(1, 2'b00, 4'b0101, 0, 0, mk_e(1, 0, 4'b0011, 0, 0, 1, 0, 0, 0, 0));
        vec[4]  = mkv(1, 2'b00, 4'b0010, 0, 1, mk_e(1, 0, 4'b0100, 0, 0, 1, 1, 0, 0, 0));
        vec[5]  = mkv(1, 2'b00, 4'b0110, 1, 0, mk_e(1, 0, 4'b0101, 0, 0, 1, 0, 0, 1, 0));
        vec[6]  = mkv(1, 2'b00, 4'b0000, 0, 0, mk_e(1, 0, 4'b0110, 0, 0, 1, 0, 0, 0, 0));
        vec[7]  = mkv(1, 2'b00, 4'b1100, 0, 0, e_orr);
        vec[8]  = mkv(1, 2'b00, 4'b0001, 0, 0, e_eor);
        vec[9]  = mkv(1, 2'b00, 4'b1010, 0, 1, mk_e(1, 0, 4'b1100, 0, 0, 0, 1, 0, 1, 0));
        vec[10] = mkv(1, 2'b00, 4'b1000, 0, 0, mk_e(1, 0, 4'b1110, 0, 0, 0, 0, 0, 1, 0));
        vec[11] = mkv(1, 2'b00, 4'b0011, 1, 1, e_ill);
        vec[12] = mkv(1, 2'b11, 4'b0100, 1, 1, e_ill);
        vec[13] = mkv(1, 2'b01, 4'b0000, 1, 1, mk_e(1, 0, 4'b0010, 1, 0, 1, 1, 0, 0, 0));
        vec[14] = mkv(1, 2'b01, 4'b0000, 0, 0, mk_e(1, 0, 4'b0010, 0, 1, 0, 0, 0, 0, 0));
        vec[15] = mkv(1, 2'b10, 4'b0000, 1, 1, e_b);
        vec[16] = mkv(1, 2'b00, 4'b0100, 0, 0, '0);
        vec[17] = mkv(1, 2'b00, 4'b1100, 0, 0, e_orr);
        vec[18] = mkv(0, 2'b00, 4'b0100, 1, 1, '0);

        rst = 1'b0;
        idle();
        model_reset();
        #2;
        cmp("reset_a", act(0), '0);
        cmp("reset_b", act(1), '0);
        #10 rst = 1'b1;

        // Decode table on the depth-1 instance.
        for (int k = 0; k < 19; k++) begin
            drive(vec[k].iv, vec[k].mode, vec[k].op, vec[k].s, vec[k].i);
            step();
            cmp($sformatf("table[%0d]", k), act(0), vec[k].e);
        end
        idle();
        repeat (3) step();

        // Depth-3 latency with back-to-back MOV, CMP, LDR.
        drive(1, 2'b00, 4'b1101, 0, 1); step();
        drive(1, 2'b00, 4'b1010, 0, 0); step();
        cmp("lat_b_e2", act(1), '0);
        drive(1, 2'b01, 4'b0000, 1, 0); step();
        cmp("lat_b_mov", act(1), e_mov);
        idle(); step();
        cmp("lat_b_cmp", act(1), e_cmp);
        step();
        cmp("lat_b_ldr", act(1), e_ldr);
        repeat (3) step();

        // Stall holds the last stage; the input offered during the stall is dropped.
        drive(1, 2'b00, 4'b0010, 0, 0); step();
        cmp("stall_a_sub", act(0), e_sub);
        stall = 1'b1;
        drive(1, 2'b00, 4'b0100, 0, 0);
        step(); cmp("stall_a_hold1", act(0), e_sub);
        step(); cmp("stall_a_hold2", act(0), e_sub);
        idle(); step();
        cmp("stall_a_nocap", act(0), '0);
        repeat (3) step();

        // Branch shadow of two on the depth-3 instance.
        drive(1, 2'b10, 4'b0000, 0, 0); step();
        drive(1, 2'b00, 4'b0100, 0, 0); step();
        drive(1, 2'b00, 4'b1100, 0, 0); step();
        cmp("shadow_b_br", act(1), e_b);
        drive(1, 2'b00, 4'b0001, 0, 0); step();
        cmp("shadow_b_bub1", act(1), '0);
        idle(); step();
        cmp("shadow_b_bub2", act(1), '0);
        step();
        cmp("shadow_b_eor", act(1), e_eor);
        repeat (3) step();

        // Flush with stall over three live entries.
        drive(1, 2'b00, 4'b0100, 0, 0); step();
        drive(1, 2'b00, 4'b0010, 0, 0); step();
        drive(1, 2'b00, 4'b0000, 0, 0); step();
        cmp("flush_b_live", act(1), e_add);
        stall = 1'b1; flush = 1'b1;
        drive(1, 2'b00, 4'b1100, 0, 0); step();
        cmp("flush_a", act(0), '0);
        cmp("flush_b", act(1), '0);
        idle();

        // Flush wins over an accepted branch, so the next instruction is not squashed.
        flush = 1'b1;
        drive(1, 2'b10, 4'b0000, 0, 0); step();
        cmp("flush_br_a", act(0), '0);
        flush = 1'b0;
        drive(1, 2'b00, 4'b0100, 0, 0); step();
        cmp("flush_br_next_a", act(0), e_add);
        idle();
        repeat (3) step();

        // Asynchronous reset mid-stream with a shadow pending.
        drive(1, 2'b10, 4'b0000, 0, 0); step();
        drive(1, 2'b00, 4'b0100, 0, 0); step();
        #2 rst = 1'b0;
        #1;
        cmp("rst_mid_a", act(0), '0);
        cmp("rst_mid_b", act(1), '0);
        model_reset();
        idle();
        #1 rst = 1'b1;
        drive(1, 2'b00, 4'b1100, 0, 0); step();
        cmp("rst_next_a", act(0), e_orr);
        idle(); step(); step();
        cmp("rst_next_b", act(1), e_orr);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom));
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 19) == 0);
            step();
        end
        idle();
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
